// File: rtl/parity_frame_rx_if.sv
// Output-side bundle of parity_frame_rx: received word, its error flags and
// the valid/ready handshake. The receiver uses the master modport.
interface parity_frame_rx_if #(
    parameter int DATA_W = 4
) ();
    logic [DATA_W-1:0] dout;
    logic              out_valid;
    logic              out_ready;
    logic              par_err;
    logic              frame_err;

    modport master (
        output dout,
        output out_valid,
        output par_err,
        output frame_err,
        input  out_ready
    );

    modport slave (
        input  dout,
        input  out_valid,
        input  par_err,
        input  frame_err,
        output out_ready
    );
endinterface

// File: rtl/parity_frame_rx.sv
// Start/data/parity/stop serial frame receiver with a valid/ready word output.
// Optional break detection is enabled by defining PARITY_FRAME_RX_BREAK_EN.
module parity_frame_rx #(
    parameter int DATA_W     = 4,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sin,
    input  logic              bit_en,
    parity_frame_rx_if.master rx,
    output logic              overrun,
`ifdef PARITY_FRAME_RX_BREAK_EN
    output logic              brk,
`endif
    output logic              busy
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                acc_q, acc_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;
    logic                complete;
    logic                is_break;
`ifdef PARITY_FRAME_RX_BREAK_EN
    logic                zero_q, zero_d;
    logic                brk_q, brk_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        ovr_d    = ovr_q;
        complete = 1'b0;
        is_break = 1'b0;
`ifdef PARITY_FRAME_RX_BREAK_EN
        zero_d   = zero_q;
        brk_d    = 1'b0;
`endif

        if (valid_q && rx.out_ready) begin
            valid_d = 1'b0;
        end

        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                        acc_d   = (ODD_PARITY != 0);
                        cnt_d   = '0;
`ifdef PARITY_FRAME_RX_BREAK_EN
                        zero_d  = 1'b1;
`endif
                    end
                end
                DATA: begin
                    // LSB arrives first, so shifting in at the top leaves it in bit 0
                    shift_d = {sin, shift_q[DATA_W-1:1]};
                    acc_d   = acc_q ^ sin;
                    cnt_d   = cnt_q + CNT_W'(1);
`ifdef PARITY_FRAME_RX_BREAK_EN
                    zero_d  = zero_q & ~sin;
`endif
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PAR;
                    end
                end
                PAR: begin
                    acc_d   = acc_q ^ sin;
`ifdef PARITY_FRAME_RX_BREAK_EN
                    zero_d  = zero_q & ~sin;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef PARITY_FRAME_RX_BREAK_EN
        is_break = zero_q & ~sin;
        if (complete && is_break) begin
            brk_d = 1'b1;
        end
`endif

        // A new word always wins; only an unaccepted predecessor counts as overrun
        if (complete && !is_break) begin
            dout_d  = shift_q;
            perr_d  = acc_q;
            ferr_d  = ~sin;
            valid_d = 1'b1;
            if (valid_q && !rx.out_ready) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef PARITY_FRAME_RX_BREAK_EN
            zero_q  <= 1'b0;
            brk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef PARITY_FRAME_RX_BREAK_EN
            zero_q  <= zero_d;
            brk_q   <= brk_d;
`endif
        end
    end

    assign rx.dout      = dout_q;
    assign rx.out_valid = valid_q;
    assign rx.par_err   = perr_q;
    assign rx.frame_err = ferr_q;
    assign overrun      = ovr_q;
    assign busy         = (state_q != IDLE);
`ifdef PARITY_FRAME_RX_BREAK_EN
    assign brk          = brk_q;
`endif
endmodule

// File: tb/tb_parity_frame_rx.sv
// Randomised scoreboard bench for parity_frame_rx: stimulus pushes expected
// words, a consumer/monitor process pops and compares on each transfer.
module tb_parity_frame_rx;
    localparam int DATA_W     = 4;
    localparam int ODD_PARITY = 0;

    typedef struct packed {
        logic [DATA_W-1:0] dout;
        logic              perr;
        logic              ferr;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic sin;
    logic bit_en;
    logic overrun;
    logic busy;
`ifdef PARITY_FRAME_RX_BREAK_EN
    logic brk;
`endif

    parity_frame_rx_if #(.DATA_W(DATA_W)) rx_if ();

    parity_frame_rx #(
        .DATA_W    (DATA_W),
        .ODD_PARITY(ODD_PARITY)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sin      (sin),
        .bit_en   (bit_en),
        .rx       (rx_if),
        .overrun  (overrun),
`ifdef PARITY_FRAME_RX_BREAK_EN
        .brk      (brk),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   total     = 0;
    int   bad       = 0;
    int   n_pushed  = 0;
    int   n_xfer    = 0;
    int   exp_brk   = 0;
    int   brk_seen  = 0;
    logic exp_ovr   = 1'b0;
    int   ready_mode = 0;  // 0 random, 1 hold low, 2 hold high

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer and monitor: picks out_ready, then scores any transfer due at the next edge
    initial begin
        exp_t e;
        rx_if.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       rx_if.out_ready = 1'($urandom_range(0, 1));
                1:       rx_if.out_ready = 1'b0;
                default: rx_if.out_ready = 1'b1;
            endcase
`ifdef PARITY_FRAME_RX_BREAK_EN
            if (reset_n && brk) brk_seen++;
`endif
            if (reset_n && rx_if.out_valid && rx_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(rx_if.dout), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    n_xfer++;
                    chk("dout", 32'(rx_if.dout), 32'(e.dout));
                    chk("par_err", 32'(rx_if.par_err), 32'(e.perr));
                    chk("frame_err", 32'(rx_if.frame_err), 32'(e.ferr));
                    chk("overrun", 32'(overrun), 32'(exp_ovr));
                    $display("xfer %0d: dout=%0h par_err=%0b frame_err=%0b overrun=%0b",
                             n_xfer, rx_if.dout, rx_if.par_err, rx_if.frame_err, overrun);
                end
            end
        end
    end

    task automatic strobe(input logic b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        sin    = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
    endtask

    // Reference: parity error when the ones-count over data+parity breaks the chosen rule
    task automatic send_frame(input logic [DATA_W-1:0] data, input logic par,
                              input logic stop, input int gap, input bit push);
        exp_t e;
`ifdef PARITY_FRAME_RX_BREAK_EN
        if (data == '0 && !par && !stop) begin
            exp_brk++;
            push = 1'b0;
        end
`endif
        if (push) begin
            e.dout = data;
            e.perr = ((($countones(data) + int'(par) + ODD_PARITY) % 2) != 0);
            e.ferr = ~stop;
            exp_q.push_back(e);
            n_pushed++;
        end
        strobe(1'b0, gap);
        for (int i = 0; i < DATA_W; i++) strobe(data[i], gap);
        strobe(par, gap);
        strobe(stop, gap);
        sin = 1'b1;
    endtask

    task automatic wait_no_valid();
        int n = 0;
        while (rx_if.out_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_accept", 32'(rx_if.out_valid), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic p;
        logic s;
        int   n;

        reset_n = 1'b0;
        sin     = 1'b1;
        bit_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_valid", 32'(rx_if.out_valid), 32'd0);
        chk("rst_dout", 32'(rx_if.dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {29'd0, rx_if.par_err, rx_if.frame_err, overrun}, 32'd0);

        // Idle line
        for (int i = 0; i < 50; i++) strobe(1'b1, 3);
        chk("idle_valid", 32'(rx_if.out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_flags", {29'd0, rx_if.par_err, rx_if.frame_err, overrun}, 32'd0);

        // Good frame 4'hD, one-cycle valid with ready held high
        ready_mode = 2;
        send_frame(4'hD, 1'b1, 1'b1, 1, 1'b1);
        chk("d_valid_now", 32'(rx_if.out_valid), 32'd1);
        chk("d_busy_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("d_valid_drop", 32'(rx_if.out_valid), 32'd0);

        send_frame(4'hD, 1'b0, 1'b1, 0, 1'b1);
        send_frame(4'hD, 1'b1, 1'b0, 2, 1'b1);
        wait_no_valid();

        // Overrun: first word is never accepted and gets overwritten
        ready_mode = 1;
        send_frame(4'h3, 1'b0, 1'b1, 1, 1'b0);
        chk("ovr_before", 32'(overrun), 32'd0);
        send_frame(4'hA, 1'b0, 1'b1, 1, 1'b1);
        exp_ovr = 1'b1;
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_dout", 32'(rx_if.dout), 32'hA);
        chk("ovr_valid", 32'(rx_if.out_valid), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_hold_valid", 32'(rx_if.out_valid), 32'd1);
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        chk("ovr_valid_drop", 32'(rx_if.out_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset mid-frame abandons the partial word
        strobe(1'b0, 1);
        chk("mid_busy", 32'(busy), 32'd1);
        strobe(1'b1, 1);
        strobe(1'b0, 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_ovr = 1'b0;
        sin     = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        chk("mid_rst_valid", 32'(rx_if.out_valid), 32'd0);
        send_frame(4'h5, 1'b0, 1'b1, 1, 1'b1);
        wait_no_valid();

        // All-zero frame
        ready_mode = 1;
        send_frame('0, 1'b0, 1'b0, 1, 1'b1);
`ifdef PARITY_FRAME_RX_BREAK_EN
        chk("brk_pulse", 32'(brk), 32'd1);
        chk("brk_no_valid", 32'(rx_if.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("brk_one_clk", 32'(brk), 32'd0);
`else
        chk("zero_valid", 32'(rx_if.out_valid), 32'd1);
        chk("zero_dout", 32'(rx_if.dout), 32'd0);
        chk("zero_ferr", 32'(rx_if.frame_err), 32'd1);
        chk("zero_perr", 32'(rx_if.par_err), 32'd0);
`endif
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;

        // Randomised frames with random strobe spacing and consumer back-pressure
        ready_mode = 0;
        for (int f = 0; f < 30; f++) begin
            wait_no_valid();
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) strobe(1'b1, $urandom_range(0, 3));
            d = DATA_W'($urandom);
            p = ((($countones(d) + ODD_PARITY) % 2) != 0);
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = ($urandom_range(0, 4) != 0);
            send_frame(d, p, s, $urandom_range(0, 3), 1'b1);
        end

        ready_mode = 2;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("xfer_count", 32'(n_xfer), 32'(n_pushed));
        chk("brk_count", 32'(brk_seen), 32'(exp_brk));
        chk("final_ovr", 32'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
